// File: rtl/divider_32.sv
// divider_32 -- sequential unsigned divider, radix-2 restoring, one quotient
// bit per clock, with a start/busy/done handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a division (accepted only while busy=0)
//   dividend     unsigned numerator, latched on acceptance
//   divisor      unsigned denominator, latched on acceptance
//   busy         high while iterations are in progress
//   done         one-cycle pulse, results valid
//   quotient     floor(dividend/divisor), all ones on divide by zero
//   remainder    dividend mod divisor, latched dividend on divide by zero
//   div_by_zero  set together with done when the divisor was 0
module divider_32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [WIDTH:0]   rem_r;    // partial remainder, one extra bit
    logic [WIDTH-1:0] quo_r;    // dividend bits shift out MSB first, quotient bits shift in
    logic [WIDTH-1:0] dvs_r;    // latched divisor

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             q_bit;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_iter;

    // One restoring step. The subtraction is carried one bit wider than the
    // remainder register so its top bit is a clean borrow/sign flag.
    always_comb begin
        shifted   = {rem_r, quo_r[WIDTH-1]};
        diff      = shifted - {2'b00, dvs_r};
        q_bit     = ~diff[WIDTH+1];
        rem_next  = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
        quo_next  = {quo_r[WIDTH-2:0], q_bit};
        last_iter = (count == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_r       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        dvs_r <= divisor;
                        quo_r <= dividend;
                        rem_r <= '0;
                        count <= '0;
                        if (divisor == '0) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    rem_r <= rem_next;
                    quo_r <= quo_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= quo_next;
                        remainder   <= rem_next[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_32.sv
// tb_divider_32 -- directed, table-driven bench for divider_32 with
// hand-written sequences for ignored start, mid-run reset and back-to-back use.
module tb_divider_32;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int tests  = 0;
    int failed = 0;

    divider_32 #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs right after acceptance, then
    // check latency, busy duration, results and the single-cycle done pulse.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er,
                         input logic ez);
        int   n;
        int   bcnt;
        logic seen;
        logic [63:0] prod;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = ~a;
        divisor  = b ^ 32'h0000_00F0;
        n = 0; bcnt = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                if (busy) bcnt++;
                n++;
            end
        end
        chk("done_seen", 64'(seen), 64'd1);
        chk("latency", 64'(n), (b == 32'd0) ? 64'd0 : 64'd32);
        chk("busy_cycles", 64'(bcnt), (b == 32'd0) ? 64'd0 : 64'd32);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("quotient", 64'(quotient), 64'(eq));
        chk("remainder", 64'(remainder), 64'(er));
        chk("div_by_zero", 64'(div_by_zero), 64'(ez));
        if (b != 32'd0) begin
            prod = 64'(quotient) * 64'(b) + 64'(remainder);
            chk("invariant_qd_r", prod, 64'(a));
            chk("invariant_r_lt_d", 64'(remainder < b), 64'd1);
        end
        @(negedge clk);
        chk("done_single_pulse", 64'(done), 64'd0);
    endtask

    int   dcnt;
    int   unstable;
    int   times[$];
    logic [31:0] q_first, r_first;

    initial begin
        vecs[0] = '{a: 32'd723123874,  b: 32'd13978,      q: 32'd51733,      r: 32'd0,          z: 1'b0};
        vecs[1] = '{a: 32'd1923842001, b: 32'd52,         q: 32'd36996961,   r: 32'd29,         z: 1'b0};
        vecs[2] = '{a: 32'd5,          b: 32'd7,          q: 32'd0,          r: 32'd5,          z: 1'b0};
        vecs[3] = '{a: 32'hFFFFFFFF,   b: 32'd1,          q: 32'hFFFFFFFF,   r: 32'd0,          z: 1'b0};
        vecs[4] = '{a: 32'd40221,      b: 32'd0,          q: 32'hFFFFFFFF,   r: 32'd40221,      z: 1'b1};
        vecs[5] = '{a: 32'd170,        b: 32'd2,          q: 32'd85,         r: 32'd0,          z: 1'b0};
        vecs[6] = '{a: 32'd0,          b: 32'd5,          q: 32'd0,          r: 32'd0,          z: 1'b0};
        vecs[7] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   q: 32'd1,          r: 32'd0,          z: 1'b0};
        vecs[8] = '{a: 32'hFFFFFFFF,   b: 32'h80000000,   q: 32'd1,          r: 32'h7FFFFFFF,   z: 1'b0};
        vecs[9] = '{a: 32'hFFFFFFFE,   b: 32'hFFFFFFFF,   q: 32'd0,          r: 32'hFFFFFFFE,   z: 1'b0};

        rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        chk("reset_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 10; v++)
            do_op(vecs[v].a, vecs[v].b, vecs[v].q, vecs[v].r, vecs[v].z);

        // start while busy is ignored, operand changes after acceptance too
        @(negedge clk);
        dividend = 32'd30855; divisor = 32'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        start = 1'b1; dividend = 32'd1612; divisor = 32'd31;
        @(negedge clk);
        start = 1'b0; dividend = 32'd7; divisor = 32'd3;
        dcnt = 0; q_first = '0; r_first = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done) begin
                if (dcnt == 0) begin
                    q_first = quotient;
                    r_first = remainder;
                end
                dcnt++;
            end
        end
        chk("ignored_start_done_count", 64'(dcnt), 64'd1);
        chk("ignored_start_quotient", 64'(q_first), 64'd121);
        chk("ignored_start_remainder", 64'(r_first), 64'd0);

        // reset in the middle of a run discards it
        @(negedge clk);
        dividend = 32'd30855; divisor = 32'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_quotient", 64'(quotient), 64'd0);
        chk("midrst_remainder", 64'(remainder), 64'd0);
        chk("midrst_dbz", 64'(div_by_zero), 64'd0);
        dcnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("midrst_no_done", 64'(dcnt), 64'd0);
        do_op(32'd1612, 32'd31, 32'd52, 32'd0, 1'b0);

        // start held high: back-to-back operations, done every 33 cycles
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        unstable = 0;
        for (int i = 0; i < 110; i++) begin
            @(negedge clk);
            if (done) begin
                times.push_back(i);
                chk("b2b_quotient", 64'(quotient), 64'd14);
                chk("b2b_remainder", 64'(remainder), 64'd2);
            end
            if (times.size() > 0 && (quotient != 32'd14 || remainder != 32'd2))
                unstable++;
        end
        start = 1'b0;
        chk("b2b_pulses", 64'(times.size()), 64'd3);
        if (times.size() >= 3) begin
            chk("b2b_first", 64'(times[0]), 64'd32);
            chk("b2b_spacing1", 64'(times[1] - times[0]), 64'd33);
            chk("b2b_spacing2", 64'(times[2] - times[1]), 64'd33);
        end
        chk("b2b_stable", 64'(unstable), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
